// File: rtl/tsp_monitor_scheduler_pkg.sv
// Shared definitions for the TS-packet monitor scheduler slice.
package tsp_pkg;

    // Scheduler FSM states.
    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_REQ       = 2'd1,
        S_WAIT_DONE = 2'd2,
        S_DONE      = 2'd3
    } tsp_state_t;

    // TS packet geometry.
    localparam int PACK_BYTE_SIZE = 188;
    localparam int PACK_WORD_SIZE = 47;

    // PID configuration word layout: PID in [12:0], pad [15:13], enable at bit 16.
    localparam int PID_W      = 13;
    localparam int PID_PAD_W  = 3;
    localparam int PID_EN_BIT = 16;

endpackage

// File: rtl/tsp_monitor_scheduler_rr_arbiter.sv
// Round-robin next-slot search: first set bit of the mask after the current
// grant, wrapping to slot 0. On the first search after reset, slot 0 itself
// is the starting point.
module tsp_rr_arbiter #(
    parameter int NUM_MONITORS = 4,
    parameter int SLOT_W       = 2
) (
    input  logic [NUM_MONITORS-1:0] i_slot_mask,
    input  logic [SLOT_W-1:0]       i_grant_slot,
    input  logic                    i_from_zero,
    output logic [SLOT_W-1:0]       o_next_slot,
    output logic                    o_found
);

    localparam int unsigned N = NUM_MONITORS;

    int unsigned       w_start;
    int unsigned       w_off;
    logic [N-1:0]      w_rot;

    // Rotate the mask so the search origin sits at bit 0, then take the lowest set bit.
    always_comb begin
        w_start     = i_from_zero ? 32'd0 : ((32'(i_grant_slot) + 32'd1) % N);
        w_rot       = N'({i_slot_mask, i_slot_mask} >> w_start);
        w_off       = 32'd0;
        o_found     = 1'b0;
        for (int unsigned i = N; i > 0; i--) begin
            if (w_rot[i-1]) begin
                w_off   = i - 32'd1;
                o_found = 1'b1;
            end
        end
        o_next_slot = SLOT_W'((w_start + w_off) % N);
    end

endmodule

// File: rtl/tsp_monitor_scheduler.sv
// Round-robin pump scheduler for the TS monitor slices, with readout mux and
// a one-entry PID configuration write buffer.
module tsp_monitor_scheduler
    import tsp_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int NUM_MONITORS       = 4,
    parameter int SLOT_W             = 2,
    parameter int TIMEOUT_CYCLES     = 65535
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 enable,
    input  logic [NUM_MONITORS-1:0]              slot_mask,
    output logic [NUM_MONITORS-1:0]              pump_data_request,
    input  logic [NUM_MONITORS-1:0]              pump_data_request_ready,
    input  logic [NUM_MONITORS*C_S_AXI_DATA_WIDTH-1:0] mon_out_data,
    input  logic [NUM_MONITORS*C_S_AXI_DATA_WIDTH-1:0] mon_out_data_index,
    output logic [C_S_AXI_DATA_WIDTH-1:0]        out_data,
    output logic [C_S_AXI_DATA_WIDTH-1:0]        out_data_index,
    output logic [SLOT_W-1:0]                    grant_slot,
    output logic                                 busy,
    output logic                                 done_pulse,
    output logic                                 timeout_pulse,
    output logic [C_S_AXI_DATA_WIDTH-1:0]        done_count,
    output logic [C_S_AXI_DATA_WIDTH-1:0]        timeout_count,
    input  logic                                 cfg_valid,
    input  logic [SLOT_W-1:0]                    cfg_slot,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]        cfg_pid,
    output logic                                 cfg_ready,
    output logic [NUM_MONITORS-1:0]              update_pid_request,
    output logic [C_S_AXI_DATA_WIDTH-1:0]        pid_index,
    output logic [C_S_AXI_DATA_WIDTH-1:0]        pid
);

    localparam int W     = C_S_AXI_DATA_WIDTH;
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [NUM_MONITORS-1:0] ONE_HOT0 = NUM_MONITORS'(1);

    tsp_state_t              r_state;
    logic [TMR_W-1:0]        r_timer;
    logic [SLOT_W-1:0]       r_grant;
    logic                    r_first;
    logic [NUM_MONITORS-1:0] r_req;
    logic                    r_busy;
    logic                    r_done_pulse;
    logic                    r_to_pulse;
    logic [W-1:0]            r_done_cnt;
    logic [W-1:0]            r_to_cnt;
    logic [W-1:0]            r_out_data;
    logic [W-1:0]            r_out_idx;

    logic                    r_pend_valid;
    logic [SLOT_W-1:0]       r_pend_slot;
    logic [W-1:0]            r_pend_pid;
    logic                    r_cfg_ready;
    logic [NUM_MONITORS-1:0] r_upd;
    logic [W-1:0]            r_pid;

    logic [SLOT_W-1:0]       w_next_slot;
    logic                    w_found;
    logic                    w_ready_g;
    logic                    w_timer_hit;
    logic                    w_leaving;
    logic                    w_cfg_blocked;

    tsp_rr_arbiter #(
        .NUM_MONITORS (NUM_MONITORS),
        .SLOT_W       (SLOT_W)
    ) u_arb (
        .i_slot_mask  (slot_mask),
        .i_grant_slot (r_grant),
        .i_from_zero  (r_first),
        .o_next_slot  (w_next_slot),
        .o_found      (w_found)
    );

    assign w_ready_g   = pump_data_request_ready[r_grant];
    assign w_timer_hit = (r_timer == TMR_W'(TIMEOUT_CYCLES - 1));

    // A pending write to the pumped slot may go out on the edge that enters
    // DONE, so the strobe lands in the DONE cycle itself.
    always_comb begin
        w_leaving = 1'b0;
        case (r_state)
            S_REQ:       w_leaving = w_ready_g && w_timer_hit;
            S_WAIT_DONE: w_leaving = w_ready_g || w_timer_hit;
            default:     w_leaving = 1'b0;
        endcase
        w_cfg_blocked = (r_pend_slot == r_grant) &&
                        ((r_state == S_REQ) || (r_state == S_WAIT_DONE)) && !w_leaving;
    end

    // Scheduler FSM: grant, request/accept handshake, completion and timeout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_timer      <= '0;
            r_grant      <= '0;
            r_first      <= 1'b1;
            r_req        <= '0;
            r_busy       <= 1'b0;
            r_done_pulse <= 1'b0;
            r_to_pulse   <= 1'b0;
            r_done_cnt   <= '0;
            r_to_cnt     <= '0;
        end else begin
            r_done_pulse <= 1'b0;
            r_to_pulse   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (enable && (slot_mask != '0) && w_found) begin
                        r_grant <= w_next_slot;
                        r_first <= 1'b0;
                        r_timer <= '0;
                        r_req   <= ONE_HOT0 << w_next_slot;
                        r_busy  <= 1'b1;
                        r_state <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (!w_ready_g) begin
                        r_req   <= '0;
                        r_timer <= '0;
                        r_state <= S_WAIT_DONE;
                    end else if (w_timer_hit) begin
                        r_req      <= '0;
                        r_to_pulse <= 1'b1;
                        r_to_cnt   <= r_to_cnt + 1'b1;
                        r_state    <= S_DONE;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                S_WAIT_DONE: begin
                    if (w_ready_g) begin
                        r_done_pulse <= 1'b1;
                        r_done_cnt   <= r_done_cnt + 1'b1;
                        r_state      <= S_DONE;
                    end else if (w_timer_hit) begin
                        r_to_pulse <= 1'b1;
                        r_to_cnt   <= r_to_cnt + 1'b1;
                        r_state    <= S_DONE;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Readout mux: follow the granted slot while busy, hold in IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_data <= '0;
            r_out_idx  <= '0;
        end else if (r_state != S_IDLE) begin
            r_out_data <= mon_out_data[r_grant*W +: W];
            r_out_idx  <= mon_out_data_index[r_grant*W +: W];
        end
    end

    // PID write buffer: accept, issue a one-cycle strobe, then reopen a cycle later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend_valid <= 1'b0;
            r_pend_slot  <= '0;
            r_pend_pid   <= '0;
            r_cfg_ready  <= 1'b1;
            r_upd        <= '0;
            r_pid        <= '0;
        end else begin
            r_upd <= '0;
            if (r_pend_valid) begin
                if (!w_cfg_blocked) begin
                    r_upd        <= ONE_HOT0 << r_pend_slot;
                    r_pid        <= r_pend_pid;
                    r_pend_valid <= 1'b0;
                end
            end else if (!r_cfg_ready) begin
                r_cfg_ready <= 1'b1;
            end else if (cfg_valid) begin
                r_pend_slot  <= cfg_slot;
                r_pend_pid   <= cfg_pid;
                r_pend_valid <= 1'b1;
                r_cfg_ready  <= 1'b0;
            end
        end
    end

    assign pump_data_request  = r_req;
    assign out_data           = r_out_data;
    assign out_data_index     = r_out_idx;
    assign grant_slot         = r_grant;
    assign busy               = r_busy;
    assign done_pulse         = r_done_pulse;
    assign timeout_pulse      = r_to_pulse;
    assign done_count         = r_done_cnt;
    assign timeout_count      = r_to_cnt;
    assign cfg_ready          = r_cfg_ready;
    assign update_pid_request = r_upd;
    assign pid_index          = '0;
    assign pid                = r_pid;

endmodule

// File: tb/tb_tsp_monitor_scheduler.sv
// Self-checking bench for tsp_monitor_scheduler with a reactive slice model.
module tb_tsp_monitor_scheduler;

    localparam int W  = 32;
    localparam int N  = 4;
    localparam int SW = 2;
    localparam int TO = 100;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            enable = 1'b0;
    logic [N-1:0]    slot_mask = '0;
    logic [N-1:0]    pump_data_request;
    logic [N-1:0]    ready;
    logic [N*W-1:0]  mon_out_data;
    logic [N*W-1:0]  mon_out_data_index;
    logic [W-1:0]    out_data, out_data_index;
    logic [SW-1:0]   grant_slot;
    logic            busy, done_pulse, timeout_pulse;
    logic [W-1:0]    done_count, timeout_count;
    logic            cfg_valid = 1'b0;
    logic [SW-1:0]   cfg_slot = '0;
    logic [W-1:0]    cfg_pid = '0;
    logic            cfg_ready;
    logic [N-1:0]    update_pid_request;
    logic [W-1:0]    pid_index, pid;

    int checks = 0;
    int errors = 0;

    logic [N-1:0] stuck = '0;
    int           lat = 50;
    int           cnt [N];
    int           req_wait_viol = 0;
    int           onehot_viol = 0;
    logic         prev_low = 1'b0;

    typedef struct packed { logic [SW-1:0] slot; logic [W-1:0] cnt; } grant_exp_t;
    typedef struct packed { logic [N-1:0] strobe; logic [W-1:0] pid; } cfg_exp_t;
    grant_exp_t gq[$];
    cfg_exp_t   cq[$];

    tsp_monitor_scheduler #(
        .C_S_AXI_DATA_WIDTH (W),
        .NUM_MONITORS       (N),
        .SLOT_W             (SW),
        .TIMEOUT_CYCLES     (TO)
    ) dut (
        .clk                     (clk),
        .rst                     (rst),
        .enable                  (enable),
        .slot_mask               (slot_mask),
        .pump_data_request       (pump_data_request),
        .pump_data_request_ready (ready),
        .mon_out_data            (mon_out_data),
        .mon_out_data_index      (mon_out_data_index),
        .out_data                (out_data),
        .out_data_index          (out_data_index),
        .grant_slot              (grant_slot),
        .busy                    (busy),
        .done_pulse              (done_pulse),
        .timeout_pulse           (timeout_pulse),
        .done_count              (done_count),
        .timeout_count           (timeout_count),
        .cfg_valid               (cfg_valid),
        .cfg_slot                (cfg_slot),
        .cfg_pid                 (cfg_pid),
        .cfg_ready               (cfg_ready),
        .update_pid_request      (update_pid_request),
        .pid_index               (pid_index),
        .pid                     (pid)
    );

    always #5 clk = ~clk;

    // Slice model: drop ready the edge after seeing a request, raise it lat cycles later.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ready <= '1;
            for (int k = 0; k < N; k++) cnt[k] <= 0;
        end else begin
            for (int k = 0; k < N; k++) begin
                if (ready[k]) begin
                    if (pump_data_request[k] && !stuck[k]) begin
                        ready[k] <= 1'b0;
                        cnt[k]   <= lat;
                    end
                end else if (cnt[k] == 0) begin
                    ready[k] <= 1'b1;
                end else begin
                    cnt[k] <= cnt[k] - 1;
                end
            end
        end
    end

    // Protocol watch: request must be one-hot on the grant and must drop after one low-ready sample.
    always @(negedge clk) begin
        logic cur;
        if (pump_data_request != '0 && pump_data_request != (N'(1) << grant_slot))
            onehot_viol++;
        cur = pump_data_request[grant_slot] && !ready[grant_slot];
        if (cur && prev_low) req_wait_viol++;
        prev_low = cur;
    end

    initial begin
        for (int k = 0; k < N; k++) begin
            mon_out_data[k*W +: W]       = 32'hA000_0000 + k;
            mon_out_data_index[k*W +: W] = 32'h0000_0100 + k;
        end
    end

    task automatic apply_reset();
        rst = 1'b1; enable = 1'b0; cfg_valid = 1'b0; stuck = '0; slot_mask = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        req_wait_viol = 0;
        onehot_viol = 0;
    endtask

    task automatic wait_idle(input string tag);
        bit ok = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (!busy) begin ok = 1'b1; break; end
        end
        checks++;
        if (!ok) begin errors++; $display("FAIL %s_idle: busy still %0b, expected 0", tag, busy); end
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({pump_data_request, busy, done_pulse, timeout_pulse, grant_slot} !== '0) begin
            errors++; $display("FAIL reset_ctrl: got %0h expected 0",
                {pump_data_request, busy, done_pulse, timeout_pulse, grant_slot});
        end
        checks++;
        if ({done_count, timeout_count} !== '0) begin
            errors++; $display("FAIL reset_counts: got %0h/%0h expected 0/0", done_count, timeout_count);
        end
        checks++;
        if ({out_data, out_data_index, pid, pid_index, update_pid_request} !== '0) begin
            errors++; $display("FAIL reset_data: out_data %0h pid %0h upd %0h expected all 0",
                out_data, pid, update_pid_request);
        end
        checks++;
        if (cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_cfg_ready: got %0b expected 1", cfg_ready); end
    endtask

    task automatic test_round_robin();
        grant_exp_t e;
        apply_reset();
        lat = 50; slot_mask = 4'b0101;
        gq.push_back('{slot: 2'd0, cnt: 32'd1});
        gq.push_back('{slot: 2'd2, cnt: 32'd2});
        gq.push_back('{slot: 2'd0, cnt: 32'd3});
        gq.push_back('{slot: 2'd2, cnt: 32'd4});
        enable = 1'b1;
        for (int c = 0; c < 1000 && gq.size() > 0; c++) begin
            @(negedge clk);
            if (done_pulse) begin
                e = gq.pop_front();
                checks++;
                if (grant_slot !== e.slot) begin errors++; $display("FAIL rr_grant: got %0d expected %0d", grant_slot, e.slot); end
                checks++;
                if (done_count !== e.cnt) begin errors++; $display("FAIL rr_done_count: got %0d expected %0d", done_count, e.cnt); end
                checks++;
                if (out_data !== (32'hA000_0000 + 32'(e.slot)) || out_data_index !== (32'h100 + 32'(e.slot))) begin
                    errors++; $display("FAIL rr_out_data: got %0h/%0h expected slot %0d words", out_data, out_data_index, e.slot);
                end
                if (gq.size() == 0) enable = 1'b0;
            end
        end
        checks++;
        if (gq.size() != 0) begin errors++; $display("FAIL rr_completion: %0d grants outstanding, expected 0", gq.size()); gq.delete(); end
        wait_idle("rr");
        checks++;
        if (req_wait_viol != 0 || onehot_viol != 0) begin
            errors++; $display("FAIL rr_request_shape: wait_viol %0d onehot_viol %0d expected 0/0", req_wait_viol, onehot_viol);
        end
        checks++;
        if (done_count !== 32'd4 || timeout_count !== 32'd0) begin
            errors++; $display("FAIL rr_final_counts: got %0d/%0d expected 4/0", done_count, timeout_count);
        end
    endtask

    task automatic test_timeout();
        int  hi = 0;
        bit  seen = 1'b0;
        bit  regrant = 1'b0;
        apply_reset();
        lat = 20; slot_mask = 4'b0010; stuck = 4'b0010; enable = 1'b1;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (timeout_pulse) begin seen = 1'b1; break; end
            if (pump_data_request[1]) hi++;
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL to_pulse: timeout_pulse not seen, expected 1"); end
        checks++;
        if (hi != TO) begin errors++; $display("FAIL to_req_cycles: got %0d expected %0d", hi, TO); end
        checks++;
        if (timeout_count !== 32'd1 || done_count !== 32'd0) begin
            errors++; $display("FAIL to_counts: got %0d/%0d expected 1/0", timeout_count, done_count);
        end
        stuck = '0;
        @(negedge clk);
        checks++;
        if (timeout_pulse !== 1'b0) begin errors++; $display("FAIL to_pulse_width: got %0b expected 0", timeout_pulse); end
        for (int c = 0; c < 10; c++) begin
            if (pump_data_request != '0) begin regrant = 1'b1; break; end
            @(negedge clk);
        end
        checks++;
        if (!regrant || grant_slot !== 2'd1 || pump_data_request !== 4'b0010) begin
            errors++; $display("FAIL to_regrant: got slot %0d req %0b expected 1/0010", grant_slot, pump_data_request);
        end
        enable = 1'b0;
        wait_idle("to");
    endtask

    task automatic test_cfg_other_slot();
        cfg_exp_t e;
        int d = 0;
        bit hit = 1'b0;
        apply_reset();
        lat = 50; slot_mask = 4'b0001; enable = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (pump_data_request[0]) begin hit = 1'b1; break; end
        end
        checks++;
        if (!hit || cfg_ready !== 1'b1) begin errors++; $display("FAIL cfg3_setup: req %0b cfg_ready %0b expected 0001/1", pump_data_request, cfg_ready); end
        cfg_slot = 2'd3; cfg_pid = 32'h0001_0100; cfg_valid = 1'b1;
        cq.push_back('{strobe: 4'b1000, pid: 32'h0001_0100});
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 1) begin
                cfg_valid = 1'b0;
                checks++;
                if (cfg_ready !== 1'b0) begin errors++; $display("FAIL cfg3_ready_drop: got %0b expected 0", cfg_ready); end
            end
            if (update_pid_request != '0) begin d = c; break; end
        end
        checks++;
        if (d != 2) begin errors++; $display("FAIL cfg3_latency: got %0d expected 2", d); end
        e = cq.pop_front();
        checks++;
        if (update_pid_request !== e.strobe || pid !== e.pid || pid_index !== 32'd0) begin
            errors++; $display("FAIL cfg3_write: upd %0b pid %0h idx %0h expected %0b/%0h/0",
                update_pid_request, pid, pid_index, e.strobe, e.pid);
        end
        @(negedge clk);
        checks++;
        if (update_pid_request !== 4'b0000 || cfg_ready !== 1'b1) begin
            errors++; $display("FAIL cfg3_after: upd %0b cfg_ready %0b expected 0000/1", update_pid_request, cfg_ready);
        end
        enable = 1'b0;
        wait_idle("cfg3");
    endtask

    task automatic test_cfg_deferred();
        cfg_exp_t e;
        bit hit = 1'b0;
        int extra = 0;
        apply_reset();
        lat = 50; slot_mask = 4'b0100; enable = 1'b1;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (busy && grant_slot == 2'd2 && pump_data_request == '0) begin hit = 1'b1; break; end
        end
        checks++;
        if (!hit) begin errors++; $display("FAIL cfg2_setup: slot 2 never reached wait, expected wait state"); end
        cfg_slot = 2'd2; cfg_pid = 32'h0001_2345; cfg_valid = 1'b1;
        cq.push_back('{strobe: 4'b0100, pid: 32'h0001_2345});
        @(negedge clk);
        cfg_slot = 2'd1; cfg_pid = 32'hDEAD_BEEF;
        checks++;
        if (cfg_ready !== 1'b0) begin errors++; $display("FAIL cfg2_ready_low: got %0b expected 0", cfg_ready); end
        @(negedge clk);
        cfg_valid = 1'b0;
        enable = 1'b0;
        hit = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (update_pid_request != '0) begin hit = 1'b1; break; end
            @(negedge clk);
        end
        e = cq.pop_front();
        checks++;
        if (!hit || done_pulse !== 1'b1) begin
            errors++; $display("FAIL cfg2_defer: strobe seen %0b done_pulse %0b expected 1/1", hit, done_pulse);
        end
        checks++;
        if (update_pid_request !== e.strobe || pid !== e.pid) begin
            errors++; $display("FAIL cfg2_write: upd %0b pid %0h expected %0b/%0h", update_pid_request, pid, e.strobe, e.pid);
        end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (update_pid_request != '0) extra++;
        end
        checks++;
        if (extra != 0 || cfg_ready !== 1'b1) begin
            errors++; $display("FAIL cfg2_dropped: extra strobes %0d cfg_ready %0b expected 0/1", extra, cfg_ready);
        end
        wait_idle("cfg2");
    endtask

    task automatic test_async_reset();
        bit hit = 1'b0;
        apply_reset();
        lat = 20; slot_mask = 4'b0011; enable = 1'b1;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (busy && grant_slot == 2'd1 && pump_data_request == '0 && !done_pulse) begin hit = 1'b1; break; end
        end
        checks++;
        if (!hit || done_count !== 32'd1) begin
            errors++; $display("FAIL rst_setup: wait on slot 1 %0b done_count %0d expected 1/1", hit, done_count);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (pump_data_request !== '0 || busy !== 1'b0 || done_count !== '0 || timeout_count !== '0 ||
            cfg_ready !== 1'b1 || grant_slot !== '0) begin
            errors++; $display("FAIL rst_async: req %0b busy %0b cnt %0d/%0d cfg_ready %0b slot %0d expected 0/0/0/0/1/0",
                pump_data_request, busy, done_count, timeout_count, cfg_ready, grant_slot);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        hit = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (pump_data_request != '0) begin hit = 1'b1; break; end
        end
        checks++;
        if (!hit || grant_slot !== 2'd0 || pump_data_request !== 4'b0001) begin
            errors++; $display("FAIL rst_first_grant: slot %0d req %0b expected 0/0001", grant_slot, pump_data_request);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (pump_data_request !== '0) begin errors++; $display("FAIL rst_req_drop: got %0b expected 0000", pump_data_request); end
        enable = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_enable_low();
        bit hit = 1'b0;
        int act = 0;
        apply_reset();
        lat = 20; slot_mask = 4'b0010; enable = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (pump_data_request[1]) begin hit = 1'b1; break; end
        end
        enable = 1'b0;
        checks++;
        if (!hit || grant_slot !== 2'd1) begin errors++; $display("FAIL en_setup: req %0b slot %0d expected 0010/1", pump_data_request, grant_slot); end
        hit = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (done_pulse) begin hit = 1'b1; break; end
        end
        checks++;
        if (!hit || done_count !== 32'd1) begin errors++; $display("FAIL en_complete: done seen %0b count %0d expected 1/1", hit, done_count); end
        @(negedge clk);
        for (int c = 0; c < 10; c++) begin
            if (busy || pump_data_request != '0) act++;
            @(negedge clk);
        end
        checks++;
        if (act != 0) begin errors++; $display("FAIL en_hold_idle: active cycles %0d expected 0", act); end
        enable = 1'b1;
        hit = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (pump_data_request != '0) begin hit = 1'b1; break; end
        end
        checks++;
        if (!hit || grant_slot !== 2'd1) begin errors++; $display("FAIL en_resume: req %0b slot %0d expected 0010/1", pump_data_request, grant_slot); end
        enable = 1'b0;
        wait_idle("en");
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_timeout();
        test_cfg_other_slot();
        test_cfg_deferred();
        test_async_reset();
        test_enable_low();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

endmodule
